// File: rtl/msh_port_arb.sv
// Output-port scheduler for one mesh node: packet-atomic round-robin over NUM_REQ
// requesters, gated by downstream credits, with a registered datapath select.
module msh_port_arb #(
    parameter int NUM_REQ = 5,
    parameter int CREDITS = 8,
    parameter int SEL_W   = $clog2(NUM_REQ),
    parameter int CRD_W   = $clog2(CREDITS + 1)
) (
    input  logic               mclk,
    input  logic               mrst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_eop,
    output logic [NUM_REQ-1:0] gnt,
    output logic               dp_vld,
    output logic [SEL_W-1:0]   dp_sel,
    output logic               dp_eop,
    input  logic               crd_rtn,
    output logic [CRD_W-1:0]   crd_cnt,
    output logic               locked,
    output logic               crd_ovf
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   owner_q, owner_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CRD_W-1:0]   crd_q, crd_d;
    logic               crd_ovf_q, crd_ovf_d;
    logic               dp_vld_q;
    logic [SEL_W-1:0]   dp_sel_q;
    logic               dp_eop_q;

    logic               can_gnt_s;
    logic               win_vld_s;
    logic [SEL_W-1:0]   win_idx_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic [SEL_W-1:0]   gnt_idx_s;
    logic               gnt_any_s;

    // Modulo-NUM_REQ index addition; NUM_REQ need not be a power of two.
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return SEL_W'(sum);
    endfunction

    // Round-robin search starting at rr_ptr_q.
    always_comb begin
        win_vld_s = 1'b0;
        win_idx_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_vld_s && req[wrap_add(rr_ptr_q, k)]) begin
                win_vld_s = 1'b1;
                win_idx_s = wrap_add(rr_ptr_q, k);
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end

    // A credit returned this cycle cannot fund this cycle's grant.
    assign can_gnt_s = mrst_n && (crd_q != CRD_W'(0));

    // Grant selection and packet-lock FSM next state.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_s     = '0;
        gnt_idx_s = '0;
        case (state_q)
            ST_IDLE: begin
                if (can_gnt_s && win_vld_s) begin
                    gnt_s[win_idx_s] = 1'b1;
                    gnt_idx_s        = win_idx_s;
                    if (req_eop[win_idx_s]) begin
                        rr_ptr_d = wrap_add(win_idx_s, 1);
                    end else begin
                        state_d = ST_PKT;
                        owner_d = win_idx_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PKT: begin
                if (can_gnt_s && req[owner_q]) begin
                    gnt_s[owner_q] = 1'b1;
                    gnt_idx_s      = owner_q;
                    if (req_eop[owner_q]) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = wrap_add(owner_q, 1);
                    end else begin
                        state_d = ST_PKT;
                    end
                end else begin
                    state_d = ST_PKT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign gnt_any_s = |gnt_s;

    // Credit counter; a return at full credit is dropped and flagged.
    always_comb begin
        crd_d     = crd_q;
        crd_ovf_d = crd_ovf_q;
        case ({gnt_any_s, crd_rtn})
            2'b10: begin
                crd_d = crd_q - CRD_W'(1);
            end
            2'b01: begin
                if (crd_q == CRD_W'(CREDITS)) begin
                    crd_ovf_d = 1'b1;
                end else begin
                    crd_d = crd_q + CRD_W'(1);
                end
            end
            default: begin
                crd_d = crd_q;
            end
        endcase
    end

    // State, credit and datapath-select registers.
    always_ff @(posedge mclk) begin
        if (!mrst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            crd_q     <= CRD_W'(CREDITS);
            crd_ovf_q <= 1'b0;
            dp_vld_q  <= 1'b0;
            dp_sel_q  <= '0;
            dp_eop_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            crd_q     <= crd_d;
            crd_ovf_q <= crd_ovf_d;
            dp_vld_q  <= gnt_any_s;
            dp_sel_q  <= gnt_idx_s;
            dp_eop_q  <= |(gnt_s & req_eop);
        end
    end

    assign gnt     = gnt_s;
    assign dp_vld  = dp_vld_q;
    assign dp_sel  = dp_sel_q;
    assign dp_eop  = dp_eop_q;
    assign crd_cnt = crd_q;
    assign locked  = (state_q == ST_PKT);
    assign crd_ovf = crd_ovf_q;

endmodule

// File: tb/tb_msh_port_arb.sv
// Directed self-checking bench for msh_port_arb (NUM_REQ=5, CREDITS=8).
module tb_msh_port_arb;

    logic       mclk;
    logic       mrst_n;
    logic [4:0] req;
    logic [4:0] req_eop;
    logic [4:0] gnt;
    logic       dp_vld;
    logic [2:0] dp_sel;
    logic       dp_eop;
    logic       crd_rtn;
    logic [3:0] crd_cnt;
    logic       locked;
    logic       crd_ovf;

    int checks = 0;
    int errors = 0;

    msh_port_arb #(.NUM_REQ(5), .CREDITS(8)) dut (
        .mclk    (mclk),
        .mrst_n  (mrst_n),
        .req     (req),
        .req_eop (req_eop),
        .gnt     (gnt),
        .dp_vld  (dp_vld),
        .dp_sel  (dp_sel),
        .dp_eop  (dp_eop),
        .crd_rtn (crd_rtn),
        .crd_cnt (crd_cnt),
        .locked  (locked),
        .crd_ovf (crd_ovf)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    initial begin
        mrst_n  = 1'b0;
        req     = 5'b00000;
        req_eop = 5'b00000;
        crd_rtn = 1'b0;
        tick();
        tick();
        req = 5'b11111;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_dp_vld", 32'(dp_vld), 32'h0);
        chk("rst_dp_sel", 32'(dp_sel), 32'h0);
        chk("rst_dp_eop", 32'(dp_eop), 32'h0);
        chk("rst_crd", 32'(crd_cnt), 32'd8);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_ovf", 32'(crd_ovf), 32'h0);
        tick();

        // Round-robin rotation with credit return held high
        mrst_n  = 1'b1;
        req     = 5'b11111;
        req_eop = 5'b11111;
        crd_rtn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_gnt", 32'(gnt), 32'(5'b00001 << (i % 5)));
            chk("rr_crd", 32'(crd_cnt), 32'd8);
            tick();
            chk("rr_dp_sel", 32'(dp_sel), 32'(i % 5));
            chk("rr_dp_vld", 32'(dp_vld), 32'h1);
            chk("rr_dp_eop", 32'(dp_eop), 32'h1);
        end
        req     = 5'b00000;
        crd_rtn = 1'b0;
        tick();
        chk("idle_dp_vld", 32'(dp_vld), 32'h0);

        // Packet lock: requester 2 owns a 4-beat packet while requester 0 waits
        req     = 5'b00101;
        req_eop = 5'b00000;
        #1;
        chk("pkt_b1_gnt", 32'(gnt), 32'b00100);
        tick();
        chk("pkt_locked", 32'(locked), 32'h1);
        chk("pkt_crd7", 32'(crd_cnt), 32'd7);
        #1;
        chk("pkt_b2_gnt", 32'(gnt), 32'b00100);
        tick();
        req = 5'b00001;
        #1;
        chk("pkt_gap_gnt", 32'(gnt), 32'b00000);
        tick();
        chk("pkt_gap_locked", 32'(locked), 32'h1);
        chk("pkt_gap_dp_vld", 32'(dp_vld), 32'h0);
        chk("pkt_gap_crd", 32'(crd_cnt), 32'd6);
        req = 5'b00101;
        #1;
        chk("pkt_b3_gnt", 32'(gnt), 32'b00100);
        tick();
        req_eop = 5'b00100;
        #1;
        chk("pkt_b4_gnt", 32'(gnt), 32'b00100);
        tick();
        chk("pkt_end_locked", 32'(locked), 32'h0);
        chk("pkt_end_dp_eop", 32'(dp_eop), 32'h1);
        chk("pkt_end_dp_sel", 32'(dp_sel), 32'd2);
        chk("pkt_end_crd", 32'(crd_cnt), 32'd4);
        req     = 5'b00001;
        req_eop = 5'b00001;
        #1;
        chk("pkt_next_gnt", 32'(gnt), 32'b00001);
        tick();
        chk("pkt_next_crd", 32'(crd_cnt), 32'd3);

        // Grant and credit return in the same cycle hold the count at 3
        req     = 5'b00010;
        req_eop = 5'b00010;
        crd_rtn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("both_gnt", 32'(gnt), 32'b00010);
            tick();
            chk("both_crd", 32'(crd_cnt), 32'd3);
        end

        // Refill to 8, then exhaust credits without returns
        req = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        chk("refill_crd", 32'(crd_cnt), 32'd8);
        chk("refill_ovf", 32'(crd_ovf), 32'h0);
        crd_rtn = 1'b0;
        req     = 5'b11111;
        req_eop = 5'b11111;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k < 8) begin
                chk("exh_gnt", 32'(gnt), 32'(5'b00001 << ((2 + k) % 5)));
            end else begin
                chk("exh_nognt", 32'(gnt), 32'h0);
            end
            tick();
        end
        chk("exh_crd0", 32'(crd_cnt), 32'd0);
        crd_rtn = 1'b1;
        #1;
        chk("exh_rtn_same_cycle", 32'(gnt), 32'h0);
        tick();
        crd_rtn = 1'b0;
        chk("exh_crd1", 32'(crd_cnt), 32'd1);
        #1;
        chk("exh_one_more", 32'(gnt), 32'b00001);
        tick();
        chk("exh_crd_back0", 32'(crd_cnt), 32'd0);
        #1;
        chk("exh_stop", 32'(gnt), 32'h0);
        tick();

        // Overflow: return one more credit than the buffer holds
        req     = 5'b00000;
        crd_rtn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        chk("ovf_full", 32'(crd_cnt), 32'd8);
        chk("ovf_clear", 32'(crd_ovf), 32'h0);
        tick();
        crd_rtn = 1'b0;
        chk("ovf_hold", 32'(crd_cnt), 32'd8);
        chk("ovf_set", 32'(crd_ovf), 32'h1);
        tick();
        tick();
        chk("ovf_sticky", 32'(crd_ovf), 32'h1);

        // Mid-packet reset during beat 2 of a 5-beat packet from requester 3
        req     = 5'b01000;
        req_eop = 5'b00000;
        #1;
        chk("mrst_b1_gnt", 32'(gnt), 32'b01000);
        tick();
        chk("mrst_locked_pre", 32'(locked), 32'h1);
        req    = 5'b01001;
        mrst_n = 1'b0;
        #1;
        chk("mrst_gnt_in_reset", 32'(gnt), 32'h0);
        tick();
        mrst_n = 1'b1;
        chk("mrst_locked", 32'(locked), 32'h0);
        chk("mrst_crd", 32'(crd_cnt), 32'd8);
        chk("mrst_ovf", 32'(crd_ovf), 32'h0);
        chk("mrst_dp_vld", 32'(dp_vld), 32'h0);
        #1;
        chk("mrst_lowest_gnt", 32'(gnt), 32'b00001);
        tick();
        chk("mrst_dp_sel", 32'(dp_sel), 32'd0);
        chk("mrst_dp_vld_after", 32'(dp_vld), 32'h1);
        chk("mrst_relock", 32'(locked), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
